// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with a two-flop input synchroniser,
// start-bit validation at half-bit, mid-bit data/stop sampling, a sticky
// framing-error flag and a wrapping good-byte counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for rxs to fall
// S_START | timing half a bit to confirm the start bit (glitch filter)
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_STOP  | sampling the stop bit at mid-bit
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] rx_count
);

  // Bit timer width; CLKS_PER_BIT must be at least 4 for the half-bit
  // compare to be meaningful.
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic [7:0]    r_rx_count;

  logic w_rxs;
  logic w_half_hit;
  logic w_full_hit;
  logic w_timer_clr;
  logic w_bit_sample;
  logic w_byte_good;
  logic w_frame_bad;

  assign w_rxs      = r_sync2;
  assign w_half_hit = (r_timer == HALF_LAST);
  assign w_full_hit = (r_timer == FULL_LAST);

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the per-cycle strobes that steer the datapath.
  always_comb begin
    w_state_next = r_state;
    w_timer_clr  = 1'b0;
    w_bit_sample = 1'b0;
    w_byte_good  = 1'b0;
    w_frame_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_clr = 1'b1;
        if (!w_rxs) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_half_hit) begin
          w_timer_clr  = 1'b1;
          // A start bit that is already high again at half-bit was noise.
          w_state_next = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full_hit) begin
          w_timer_clr  = 1'b1;
          w_bit_sample = 1'b1;
          if (r_idx == 3'd7) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_full_hit) begin
          w_timer_clr = 1'b1;
          // Leaving at mid stop bit lets a back-to-back start edge be seen.
          if (w_rxs) begin
            w_byte_good  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_bad  = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_timer_clr = 1'b1;
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_timer_clr  = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Bit timer: counts up inside a bit, restarts on every state change and
  // at each sample point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + CW'(1);
    end
  end

  // Data-bit index; parked at zero outside DATA so each frame starts at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= 3'd0;
    end else if (r_state != S_DATA) begin
      r_idx <= 3'd0;
    end else if (w_bit_sample) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  // Assembly register, filled LSB first at each mid-bit sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 8'h00;
    end else if (w_bit_sample) begin
      r_shift[r_idx] <= w_rxs;
    end
  end

  // Output registers: publish good bytes, track framing errors and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_count  <= 8'h00;
    end else begin
      r_rx_valid <= w_byte_good;
      if (w_byte_good) begin
        r_rx_data   <= r_shift;
        r_frame_err <= 1'b0;
        r_rx_count  <= r_rx_count + 8'd1;
      end else if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_count  = r_rx_count;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: drives 8N1 frames at the exact bit period and checks the
// receiver against a frame-level reference model (expected byte queue with
// pulse times, counter, sticky error flag).
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] rx_count;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy),
    .rx_count (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_double = 0;
  logic prev_valid = 1'b0;

  // Reference model state.
  logic [7:0] m_data  = 8'h00;
  logic [7:0] m_count = 8'h00;
  logic       m_ferr  = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] obs_q[$];
  int         obs_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor.
  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back(rx_data);
      obs_t.push_back(cyc);
    end
    if (rx_valid && prev_valid) n_double++;
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    int t0;
    f  = {stop_bit, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      step(CPB);
    end
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_t.push_back(t0 + LAT);
      m_data  = b;
      m_count = m_count + 8'd1;
      m_ferr  = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_levels(input string tag);
    @(negedge clk);
    check({tag, "_data"}, rx_data, m_data);
    check({tag, "_count"}, rx_count, m_count);
    check({tag, "_ferr"}, frame_err, m_ferr);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_pulses(input string tag);
    int no, ne, lat_got;
    no = obs_q.size();
    ne = exp_q.size();
    check({tag, "_npulse"}, no, ne);
    for (int i = 0; i < ((no < ne) ? no : ne); i++) begin
      check({tag, "_pval"}, obs_q[i], exp_q[i]);
      lat_got = (obs_t[i] >= exp_t[i] - 1 && obs_t[i] <= exp_t[i] + 1) ? exp_t[i] : obs_t[i];
      check({tag, "_ptime"}, lat_got, exp_t[i]);
    end
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
    exp_t.delete();
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_count = 8'h00;
    m_ferr  = 1'b0;
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
    exp_t.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f;
    int busy_wait;
    logic [7:0] rb;

    reset = 1'b1;
    rxd   = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", rx_count, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(20);

    // Single good byte.
    send_frame(8'h55, 1'b1);
    step(2);
    compare_pulses("t1");
    check_levels("t1");
    check("t1_busy", busy, 1'b0);

    // Short low glitch must be rejected.
    rxd = 1'b0;
    step(5);
    rxd = 1'b1;
    busy_wait = 0;
    while (busy && busy_wait < 10) begin
      step(1);
      busy_wait++;
    end
    check("t2_busy_idle", busy, 1'b0);
    step(20);
    compare_pulses("t2");
    check_levels("t2");

    // Framing error, held break, then recovery.
    send_frame(8'hA3, 1'b0);
    rxd = 1'b0;
    step(40);
    check_levels("t3a");
    rxd = 1'b1;
    step(6);
    send_frame(8'h0F, 1'b1);
    step(2);
    compare_pulses("t3b");
    check_levels("t3b");

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(2);
    compare_pulses("t4");
    check_levels("t4");

    // Reset in the middle of data bit 4.
    f = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = f[i];
      step(CPB);
    end
    rxd = f[5];
    step(8);
    reset = 1'b1;
    rxd   = 1'b1;
    #1;
    check("t5_rst_data", rx_data, 8'h00);
    check("t5_rst_valid", rx_valid, 1'b0);
    check("t5_rst_ferr", frame_err, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_count", rx_count, 8'h00);
    model_reset();
    step(3);
    reset = 1'b0;
    step(32);
    send_frame(8'hC3, 1'b1);
    step(2);
    compare_pulses("t5");
    check_levels("t5");

    // 256 random good bytes from a clean reset: counter wraps to zero.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    model_reset();
    step(4);
    for (int n = 0; n < 256; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1);
      step($urandom_range(0, 3));
    end
    step(2);
    check("t6_npulse256", obs_q.size(), 256);
    compare_pulses("t6");
    check_levels("t6");
    check("t6_count_wrap", rx_count, 8'h00);
    check("no_double_valid", n_double, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
